fp_add: RTL and testbench

- IEEE 754 binary32/binary64 floating-point adder/subtractor for the FPU execute stage.
- Handles all operand classes (zero, subnormal, normal, infinity, qNaN, sNaN), five rounding modes, and full exception flags.
- Pipelined with one register stage: operands are captured on a clock edge and the result is available after that edge.

---
 rtl/fp_add.sv | 206 ++++++++++++++++++++
 tb/tb_fp_add.sv | 97 +++++++++
 2 files changed

// File: rtl/fp_add.sv
// IEEE 754 binary32/binary64 add/subtract with all operand classes, five rounding modes and exception flags.
// One register stage: operands are sampled on the rising clk edge and the result is held until the next edge; there is no handshake.
module fp_add (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic [2:0]  rm,
  input  logic [2:0]  op_type,
  input  logic        P,
  input  logic        OvEn,
  input  logic        UnEn,
  output logic [63:0] result,
  output logic [4:0]  Flags,
  output logic        Denorm
);

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef struct packed {
    logic        s;
    logic [12:0] e;     // biased exponent, subnormals read as 1
    logic [52:0] m;     // significand with hidden bit; binary32 left-aligned
    logic        inf;
    logic        nan;
    logic        snan;
  } unp_t;

  function automatic unp_t unpack_op(input logic [63:0] x, input logic sp);
    unp_t        u;
    logic [10:0] ef;
    logic [51:0] fr;
    logic        e_max;
    if (sp) begin
      ef    = {3'b000, x[62:55]};
      fr    = {x[54:32], 29'd0};
      e_max = &x[62:55];
    end else begin
      ef    = x[62:52];
      fr    = x[51:0];
      e_max = &x[62:52];
    end
    u.s    = x[63];
    u.e    = (ef == 11'd0) ? 13'd1 : {2'b00, ef};
    u.m    = {(ef != 11'd0), fr};
    u.inf  = e_max && (fr == 52'd0);
    u.nan  = e_max && (fr != 52'd0);
    u.snan = u.nan && !fr[51];
    return u;
  endfunction

  function automatic logic [63:0] pack_op(input logic s, input logic [10:0] e,
                                          input logic [52:0] k, input logic sp);
    if (sp) return {s, e[7:0], k[22:0], 32'd0};
    else    return {s, e, k[51:0]};
  endfunction

  function automatic logic [6:0] lzc56(input logic [55:0] v);
    logic [6:0] n;
    logic       hit;
    n   = 7'd56;
    hit = 1'b0;
    for (int i = 55; i >= 0; i--) begin
      if (!hit && v[i]) begin
        n   = 7'(55 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction

  unp_t               ua, ub, big, sml;
  logic               a_big, eff_sub;
  logic [12:0]        d, lim;
  logic [55:0]        ext_s, shifted, lost, al, norm;
  logic [56:0]        sum;
  logic [6:0]         lz, sh;
  logic               tiny;
  logic signed [13:0] e_n, e_r, maxe, bias_adj, ef_w;
  logic [52:0]        kept, k;
  logic [53:0]        rnd;
  logic               g, st, nx, rup, carry, hid, ovf, ovf_inf, sgn;
  logic [63:0]        res_d, qnan;
  logic [4:0]         flg_d;
  logic               den_d;

  always_comb begin
    ua      = unpack_op(op1, P);
    ub      = unpack_op(op2, P);
    ub.s    = op2[63] ^ (op_type == 3'b001);
    a_big   = {ua.e, ua.m} >= {ub.e, ub.m};
    big     = a_big ? ua : ub;
    sml     = a_big ? ub : ua;
    eff_sub = ua.s ^ ub.s;
    sgn     = big.s;

    // align the smaller operand, folding everything shifted out into sticky
    d       = big.e - sml.e;
    ext_s   = {sml.m, 3'b000};
    shifted = '0;
    lost    = '0;
    al      = {55'd0, |sml.m};
    if (d < 13'd56) begin
      shifted = ext_s >> d[5:0];
      lost    = ext_s & ~({56{1'b1}} << d[5:0]);
      al      = {shifted[55:1], shifted[0] | (|lost)};
    end

    sum = eff_sub ? ({1'b0, big.m, 3'b000} - {1'b0, al})
                  : ({1'b0, big.m, 3'b000} + {1'b0, al});

    // tiny sums are always exact, so the trap path may normalise fully
    lz   = lzc56(sum[55:0]);
    lim  = big.e - 13'd1;
    tiny = (sum != 57'd0) && !sum[56] && ({6'd0, lz} >= big.e);
    sh   = (!UnEn && ({6'd0, lz} > lim)) ? lim[6:0] : lz;
    if (sum[56]) begin
      norm = {sum[56:2], sum[1] | sum[0]};
      e_n  = $signed({1'b0, big.e}) + 14'sd1;
    end else begin
      norm = sum[55:0] << sh;
      e_n  = $signed({1'b0, big.e}) - $signed({7'd0, sh});
    end

    if (P) begin
      kept = {29'd0, norm[55:32]};
      g    = norm[31];
      st   = |norm[30:0];
    end else begin
      kept = norm[55:3];
      g    = norm[2];
      st   = |norm[1:0];
    end
    nx = g | st;
    case (rm)
      RM_RTZ:  rup = 1'b0;
      RM_RDN:  rup = sgn & nx;
      RM_RUP:  rup = ~sgn & nx;
      RM_RMM:  rup = g;
      default: rup = g & (st | kept[0]);
    endcase
    rnd   = {1'b0, kept} + {53'd0, rup};
    carry = P ? rnd[24] : rnd[53];
    k     = carry ? rnd[53:1] : rnd[52:0];
    e_r   = carry ? e_n + 14'sd1 : e_n;
    hid   = P ? k[23] : k[52];

    maxe     = P ? 14'sd255 : 14'sd2047;
    bias_adj = P ? 14'sd192 : 14'sd1536;
    ovf      = hid && (e_r >= maxe);
    case (rm)
      RM_RTZ:  ovf_inf = 1'b0;
      RM_RDN:  ovf_inf = sgn;
      RM_RUP:  ovf_inf = ~sgn;
      default: ovf_inf = 1'b1;
    endcase

    if (ovf && OvEn)       ef_w = e_r - bias_adj;
    else if (tiny && UnEn) ef_w = e_r + bias_adj;
    else if (hid)          ef_w = e_r;
    else                   ef_w = 14'sd0;

    qnan  = P ? {32'h7FC00000, 32'd0} : 64'h7FF8000000000000;
    res_d = pack_op(sgn, ef_w[10:0], k, P);
    flg_d = {3'b000, tiny && (UnEn || nx), nx};

    if (ua.nan || ub.nan) begin
      res_d = qnan;
      flg_d = {ua.snan | ub.snan, 4'b0000};
    end else if (ua.inf && ub.inf && eff_sub) begin
      res_d = qnan;
      flg_d = 5'b10000;
    end else if (ua.inf || ub.inf) begin
      res_d = pack_op(ua.inf ? ua.s : ub.s, 11'h7FF, 53'd0, P);
      flg_d = 5'b00000;
    end else if (sum == 57'd0) begin
      res_d = pack_op(eff_sub ? (rm == RM_RDN) : ua.s, 11'd0, 53'd0, P);
      flg_d = 5'b00000;
    end else if (ovf) begin
      flg_d = 5'b00101;
      if (!OvEn) begin
        res_d = ovf_inf ? pack_op(sgn, 11'h7FF, 53'd0, P)
                        : pack_op(sgn, P ? 11'h0FE : 11'h7FE, {53{1'b1}}, P);
      end
    end

    den_d = P ? ((res_d[62:55] == 8'd0) && (res_d[54:32] != 23'd0))
              : ((res_d[62:52] == 11'd0) && (res_d[51:0] != 52'd0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      Flags  <= '0;
      Denorm <= 1'b0;
    end else begin
      result <= res_d;
      Flags  <= flg_d;
      Denorm <= den_d;
    end
  end

endmodule

// File: tb/tb_fp_add.sv
// Directed-vector bench for fp_add with hand-computed expected results.
module tb_fp_add;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] op1 = '0, op2 = '0;
  logic [2:0]  rm = '0, op_type = '0;
  logic        P = 1'b0, OvEn = 1'b0, UnEn = 1'b0;
  logic [63:0] result;
  logic [4:0]  Flags;
  logic        Denorm;

  int n_checks = 0;
  int n_errors = 0;

  fp_add dut (
    .clk(clk), .reset_n(reset_n), .op1(op1), .op2(op2), .rm(rm),
    .op_type(op_type), .P(P), .OvEn(OvEn), .UnEn(UnEn),
    .result(result), .Flags(Flags), .Denorm(Denorm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sp(input logic [31:0] x);
    return {x, 32'd0};
  endfunction

  task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic [2:0] r, input logic [2:0] t, input logic p,
                     input logic ov, input logic un,
                     input logic [63:0] exp_res, input logic [4:0] exp_flg, input logic exp_den);
    op1 = a; op2 = b; rm = r; op_type = t; P = p; OvEn = ov; UnEn = un;
    @(posedge clk);
    #1;
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flg"}, {59'd0, Flags}, {59'd0, exp_flg});
    check({tag, "_den"}, {63'd0, Denorm}, {63'd0, exp_den});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", result, 64'd0);
    check("rst_flg", {59'd0, Flags}, 64'd0);
    check("rst_den", {63'd0, Denorm}, 64'd0);
    reset_n = 1'b1;

    run("sp_1p1",    sp(32'h3F800000), sp(32'h3F800000), 3'b000, 3'b000, 1, 0, 0, sp(32'h40000000), 5'b00000, 0);
    run("sp_mix",    sp(32'h3FC00000), sp(32'h40100000), 3'b000, 3'b000, 1, 0, 0, sp(32'h40700000), 5'b00000, 0);
    run("tie_rne",   sp(32'h3F800000), sp(32'h33800000), 3'b000, 3'b000, 1, 0, 0, sp(32'h3F800000), 5'b00001, 0);
    run("tie_rup",   sp(32'h3F800000), sp(32'h33800000), 3'b011, 3'b000, 1, 0, 0, sp(32'h3F800001), 5'b00001, 0);
    run("tie_rmm",   sp(32'h3F800000), sp(32'h33800000), 3'b100, 3'b000, 1, 0, 0, sp(32'h3F800001), 5'b00001, 0);
    run("tie_rsvd",  sp(32'h3F800000), sp(32'h33800000), 3'b111, 3'b000, 1, 0, 0, sp(32'h3F800000), 5'b00001, 0);
    run("ovf_rne",   sp(32'h7F7FFFFF), sp(32'h7F7FFFFF), 3'b000, 3'b000, 1, 0, 0, sp(32'h7F800000), 5'b00101, 0);
    run("ovf_rtz",   sp(32'h7F7FFFFF), sp(32'h7F7FFFFF), 3'b001, 3'b000, 1, 0, 0, sp(32'h7F7FFFFF), 5'b00101, 0);
    run("ovf_trap",  sp(32'h7F7FFFFF), sp(32'h7F7FFFFF), 3'b000, 3'b000, 1, 1, 0, sp(32'h1FFFFFFF), 5'b00101, 0);
    run("inf_m_inf", sp(32'h7F800000), sp(32'hFF800000), 3'b000, 3'b000, 1, 0, 0, sp(32'h7FC00000), 5'b10000, 0);
    run("snan",      sp(32'h7F800001), sp(32'h3F800000), 3'b000, 3'b000, 1, 0, 0, sp(32'h7FC00000), 5'b10000, 0);
    run("qnan",      sp(32'h3F800000), sp(32'h7FC00001), 3'b000, 3'b000, 1, 0, 0, sp(32'h7FC00000), 5'b00000, 0);
    run("inf_fin",   sp(32'h7F800000), sp(32'h3F800000), 3'b000, 3'b001, 1, 0, 0, sp(32'h7F800000), 5'b00000, 0);
    run("sub_den",   sp(32'h00800000), sp(32'h00400000), 3'b000, 3'b001, 1, 0, 0, sp(32'h00400000), 5'b00000, 1);
    run("sub_untrp", sp(32'h00800000), sp(32'h00400000), 3'b000, 3'b001, 1, 0, 1, sp(32'h60000000), 5'b00010, 0);
    run("zero_rne",  sp(32'h3F800000), sp(32'h3F800000), 3'b000, 3'b001, 1, 0, 0, sp(32'h00000000), 5'b00000, 0);
    run("zero_rdn",  sp(32'h3F800000), sp(32'h3F800000), 3'b010, 3'b001, 1, 0, 0, sp(32'h80000000), 5'b00000, 0);
    run("nzero_sum", sp(32'h80000000), sp(32'h80000000), 3'b000, 3'b000, 1, 0, 0, sp(32'h80000000), 5'b00000, 0);
    run("dp_sub",    64'h3FF0000000000000, 64'h3FE0000000000000, 3'b000, 3'b001, 0, 0, 0, 64'h3FE0000000000000, 5'b00000, 0);
    run("dp_1p1",    64'h3FF0000000000000, 64'h3FF0000000000000, 3'b000, 3'b000, 0, 0, 0, 64'h4000000000000000, 5'b00000, 0);

    // asynchronous reset between edges, inputs still presenting dp 1+1
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_res", result, 64'd0);
    check("arst_flg", {59'd0, Flags}, 64'd0);
    @(posedge clk);
    #1;
    check("arst_hold", result, 64'd0);
    reset_n = 1'b1;
    #2;
    check("arst_rel", result, 64'd0);
    @(posedge clk);
    #1;
    check("arst_post", result, 64'h4000000000000000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
